message_queue_mc: RTL

MESSAGE_QUEUE_MC -- requirements
Module: message_queue_mc

---
 rtl/message_queue_mc.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/message_queue_mc.sv
// Multi-channel packet queue: stores NoC packets into per-channel circular FIFOs
// and presents their heads to a bus interface with round-robin channel selection.
module message_queue_mc #(
   parameter  int N_CHANNELS        = 2,
   parameter  int QUEUE_DEPTH       = 4,
   parameter  int FLIT_WIDTH        = 16,
   parameter  int MAX_PACKET_LENGTH = 5,
   localparam int CH_BITS  = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1,
   localparam int LEN_BITS = $clog2(MAX_PACKET_LENGTH),
   localparam int PTR_BITS = $clog2(QUEUE_DEPTH),
   localparam int PKT_W    = MAX_PACKET_LENGTH * FLIT_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [PKT_W-1:0]        in_link_i,
   input  logic [CH_BITS-1:0]      in_ch_i,
   input  logic                    r_pkt_to_msg_i,
   output logic                    g_pkt_to_msg_o,
   output logic [N_CHANNELS-1:0]   full_o,
   input  logic                    next_data_i,
   input  logic                    retry_i,
   input  logic                    message_transmitted_i,
   output logic                    r_bus_arbitration_o,
   output logic [CH_BITS-1:0]      ch_o,
   output logic [FLIT_WIDTH-1:0]   address_o,
   output logic [FLIT_WIDTH-1:0]   data_o,
   output logic [FLIT_WIDTH/8-1:0] sel_o,
   output logic                    transaction_type_o,
   output logic [LEN_BITS-1:0]     burst_lenght_o
);

   localparam int CH_SPAN = 1 << CH_BITS;

   typedef enum logic {S_IDLE, S_SEND} state_t;

   state_t                r_state;
   logic [PKT_W-1:0]      r_mem    [N_CHANNELS][QUEUE_DEPTH];
   logic [PTR_BITS-1:0]   r_wr_ptr [N_CHANNELS];
   logic [PTR_BITS-1:0]   r_rd_ptr [N_CHANNELS];
   logic [PTR_BITS:0]     r_count  [N_CHANNELS];
   logic [N_CHANNELS-1:0] r_full;
   logic [CH_BITS-1:0]    r_ch;
   logic [CH_BITS-1:0]    r_last;
   logic [LEN_BITS-1:0]   r_beat;

   logic                  w_in_range;
   logic [CH_SPAN-1:0]    w_full_pad;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_send;
   logic [N_CHANNELS-1:0] w_push_vec;
   logic [N_CHANNELS-1:0] w_pop_vec;
   logic [PTR_BITS:0]     w_count_nxt [N_CHANNELS];
   logic                  w_found;
   logic [CH_BITS-1:0]    w_sel;
   logic [CH_BITS-1:0]    w_idx;
   logic [PTR_BITS-1:0]   w_rd;
   logic [LEN_BITS-1:0]   w_n_raw;
   logic [LEN_BITS-1:0]   w_n;
   logic                  w_we;
   logic                  w_beat_adv;
   logic [FLIT_WIDTH-1:0] w_addr;
   logic [FLIT_WIDTH-1:0] w_data;

   // Padding lets an out-of-range channel index the full vector safely.
   assign w_full_pad     = CH_SPAN'(r_full);
   assign w_in_range     = ({1'b0, in_ch_i} < (CH_BITS+1)'(N_CHANNELS));
   assign g_pkt_to_msg_o = r_pkt_to_msg_i && w_in_range && !w_full_pad[in_ch_i];
   assign w_push         = g_pkt_to_msg_o;
   assign w_send         = (r_state == S_SEND);
   assign w_pop          = w_send && message_transmitted_i;
   assign full_o         = r_full;

   always_comb begin
      for (int c = 0; c < N_CHANNELS; c++) begin
         w_push_vec[c]  = w_push && (in_ch_i == CH_BITS'(c));
         w_pop_vec[c]   = w_pop && (r_ch == CH_BITS'(c));
         w_count_nxt[c] = r_count[c] + (PTR_BITS+1)'(w_push_vec[c])
                                     - (PTR_BITS+1)'(w_pop_vec[c]);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int c = 0; c < N_CHANNELS; c++) begin
            r_wr_ptr[c] <= '0;
            r_rd_ptr[c] <= '0;
            r_count[c]  <= '0;
         end
         r_full <= '0;
      end else begin
         for (int c = 0; c < N_CHANNELS; c++) begin
            if (w_push_vec[c]) r_wr_ptr[c] <= r_wr_ptr[c] + PTR_BITS'(1);
            if (w_pop_vec[c])  r_rd_ptr[c] <= r_rd_ptr[c] + PTR_BITS'(1);
            r_count[c] <= w_count_nxt[c];
            r_full[c]  <= (w_count_nxt[c] == (PTR_BITS+1)'(QUEUE_DEPTH));
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[in_ch_i][r_wr_ptr[in_ch_i]] <= in_link_i;
   end

   // Scan downwards so the nearest channel after r_last is the one kept.
   always_comb begin
      w_found = 1'b0;
      w_sel   = '0;
      w_idx   = '0;
      for (int i = N_CHANNELS; i >= 1; i--) begin
         w_idx = CH_BITS'((int'(r_last) + i) % N_CHANNELS);
         if (r_count[w_idx] != '0) begin
            w_found = 1'b1;
            w_sel   = w_idx;
         end
      end
   end

   assign w_rd    = r_rd_ptr[r_ch];
   assign w_n_raw = r_mem[r_ch][w_rd][LEN_BITS-1:0];
   assign w_we    = r_mem[r_ch][w_rd][LEN_BITS];
   assign w_addr  = r_mem[r_ch][w_rd][FLIT_WIDTH +: FLIT_WIDTH];
   assign w_n     = (w_n_raw > LEN_BITS'(MAX_PACKET_LENGTH-2))
                    ? LEN_BITS'(MAX_PACKET_LENGTH-2) : w_n_raw;
   assign w_beat_adv = (({1'b0, r_beat} + (LEN_BITS+1)'(1)) < {1'b0, w_n});

   always_comb begin
      w_data = '0;
      for (int k = 2; k < MAX_PACKET_LENGTH; k++) begin
         if (r_beat == LEN_BITS'(k-2)) w_data = r_mem[r_ch][w_rd][k*FLIT_WIDTH +: FLIT_WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_ch    <= '0;
         r_beat  <= '0;
         r_last  <= CH_BITS'(N_CHANNELS-1);
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_ch    <= w_sel;
                  r_beat  <= '0;
                  r_state <= S_SEND;
               end
            end
            S_SEND: begin
               if (message_transmitted_i) begin
                  r_last  <= r_ch;
                  r_beat  <= '0;
                  r_state <= S_IDLE;
               end else if (retry_i) begin
                  r_beat <= '0;
               end else if (next_data_i && w_beat_adv) begin
                  r_beat <= r_beat + LEN_BITS'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign r_bus_arbitration_o = w_send;
   assign ch_o                = w_send ? r_ch : '0;
   assign address_o           = w_send ? w_addr : '0;
   assign data_o              = (w_send && (w_n != '0)) ? w_data : '0;
   assign sel_o               = {(FLIT_WIDTH/8){w_send}};
   assign transaction_type_o  = w_send && w_we;
   assign burst_lenght_o      = w_send ? w_n : '0;

endmodule
